// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. Holds the fetch PC, reads the combinational
//   instruction memory at pc_addr and queues {pc, instr, fault} entries in a
//   2-deep FIFO for decode. A misaligned PC produces a single fault entry
//   carrying NOP_INSTR and stops fetching until a redirect arrives.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   pc_addr           current fetch address to instruction memory
//   instruction       instruction word at pc_addr (combinational return)
//   redirect_valid    flush the FIFO and restart fetching at redirect_pc
//   redirect_pc       new fetch address
//   out_valid/ready   valid/ready handshake toward decode
//   out_pc/instr      head entry contents (zero while the FIFO is empty)
//   out_fault         head entry is an instruction-address-misaligned fault
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] pc_addr,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    entry_t      head_q, head_d;   // entry presented to decode
    entry_t      tail_q, tail_d;   // second entry, valid only when count_q == 2

    logic        deq;
    logic        enq;
    logic        misaligned;
    entry_t      new_entry;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;

        deq        = (count_q != 2'd0) && out_ready;
        misaligned = (pc_q[1:0] != 2'b00);
        enq        = (state_q == RUN) && !redirect_valid &&
                     ((count_q != 2'd2) || deq);

        new_entry.pc    = pc_q;
        new_entry.instr = misaligned ? NOP_INSTR : instruction;
        new_entry.fault = misaligned;

        if (redirect_valid) begin
            // Redirect wins over everything, including a dequeue this cycle:
            // the whole FIFO is dropped, so the handshake is lost with it.
            count_d = 2'd0;
            pc_d    = redirect_pc;
            state_d = RUN;
        end else begin
            // Dequeue shifts the tail into the head; the new entry then lands
            // in the first free slot, which keeps order on simultaneous
            // enqueue and dequeue.
            if (deq) begin
                head_d  = tail_q;
                count_d = count_d - 2'd1;
            end
            if (enq) begin
                if (count_d == 2'd0) begin
                    head_d = new_entry;
                end else begin
                    tail_d = new_entry;
                end
                count_d = count_d + 2'd1;
                if (misaligned) begin
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + 64'd4;
                end
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
            // NOTE: the FIFO storage is only two entries, so it is reset too;
            // outputs are gated by count anyway, this just keeps it X-free.
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign pc_addr   = pc_q;
    assign out_valid = (count_q != 2'd0);
    assign out_pc    = out_valid ? head_q.pc    : 64'd0;
    assign out_instr = out_valid ? head_q.instr : 32'd0;
    assign out_fault = out_valid ? head_q.fault : 1'b0;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A small instruction-memory model answers
//   pc_addr combinationally; each step advances one rising edge and samples
//   1 time unit later. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [63:0] pc_addr;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    int total = 0;
    int bad   = 0;

    fetch_unit #(
        .RESET_PC (64'h0),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_addr       (pc_addr),
        .instruction   (instruction),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_fault     (out_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: two fixed words, everything else a tagged word
    // {16'hC0DE, word index}.
    always_comb begin
        case (pc_addr[17:2])
            16'h0000: instruction = 32'h00A0_0093;
            16'h0001: instruction = 32'h0010_8113;
            default:  instruction = {16'hC0DE, pc_addr[17:2]};
        endcase
    end

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;

        // Reset state, checked before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_pc",    pc_addr,   64'h0);
        check("rst_valid", out_valid, 64'h0);
        check("rst_opc",   out_pc,    64'h0);
        check("rst_instr", out_instr, 64'h0);
        check("rst_fault", out_fault, 64'h0);
        #10 rst = 1'b0;   // t=12, first edge after release at t=15

        // Streaming with out_ready=1.
        step();
        check("s1_valid", out_valid, 64'h1);
        check("s1_opc",   out_pc,    64'h0);
        check("s1_instr", out_instr, 64'h00A0_0093);
        check("s1_fault", out_fault, 64'h0);
        check("s1_pc",    pc_addr,   64'h4);
        step();
        check("s2_opc",   out_pc,    64'h4);
        check("s2_instr", out_instr, 64'h0010_8113);
        check("s2_pc",    pc_addr,   64'h8);

        // Back-pressure from reset: fill, stall, then drain in order.
        rst = 1'b1;
        out_ready = 1'b0;
        #1;
        check("r2_valid", out_valid, 64'h0);
        #1 rst = 1'b0;
        step();
        check("bp1_pc",  pc_addr, 64'h4);
        step();
        check("bp2_pc",  pc_addr, 64'h8);
        check("bp2_opc", out_pc,  64'h0);
        step(); step(); step();
        check("bp5_pc",    pc_addr,   64'h8);
        check("bp5_opc",   out_pc,    64'h0);
        check("bp5_instr", out_instr, 64'h00A0_0093);
        out_ready = 1'b1;
        step();
        check("dr1_opc",   out_pc,    64'h4);
        check("dr1_instr", out_instr, 64'h0010_8113);
        check("dr1_pc",    pc_addr,   64'hC);
        step();
        check("dr2_opc",   out_pc,    64'h8);
        check("dr2_instr", out_instr, 64'hC0DE_0002);
        check("dr2_valid", out_valid, 64'h1);
        step();
        check("dr3_opc",   out_pc,    64'hC);

        // Redirect with full FIFO and a dequeue in the same cycle.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        step();
        redirect_valid = 1'b0;
        check("rd_valid", out_valid, 64'h0);
        check("rd_pc",    pc_addr,   64'h100);
        check("rd_opc0",  out_pc,    64'h0);
        step();
        check("rd1_valid", out_valid, 64'h1);
        check("rd1_opc",   out_pc,    64'h100);
        check("rd1_instr", out_instr, 64'hC0DE_0040);
        check("rd1_pc",    pc_addr,   64'h104);

        // Misaligned redirect: one fault entry, then halt.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h102;
        step();
        redirect_valid = 1'b0;
        check("mis_valid0", out_valid, 64'h0);
        check("mis_pc0",    pc_addr,   64'h102);
        step();
        check("mis_valid", out_valid, 64'h1);
        check("mis_opc",   out_pc,    64'h102);
        check("mis_instr", out_instr, 64'h13);
        check("mis_fault", out_fault, 64'h1);
        check("mis_pc",    pc_addr,   64'h102);
        step();
        check("halt1_valid", out_valid, 64'h0);
        check("halt1_pc",    pc_addr,   64'h102);
        step(); step();
        check("halt3_valid", out_valid, 64'h0);
        check("halt3_pc",    pc_addr,   64'h102);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        step();
        redirect_valid = 1'b0;
        check("rec_pc0", pc_addr, 64'h200);
        step();
        check("rec_valid", out_valid, 64'h1);
        check("rec_opc",   out_pc,    64'h200);
        check("rec_fault", out_fault, 64'h0);
        check("rec_pc",    pc_addr,   64'h204);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        check("wrap_opc",   out_pc,    64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_instr", out_instr, 64'hC0DE_FFFF);
        check("wrap_pc",    pc_addr,   64'h0);
        step();
        check("wrap2_opc",   out_pc,    64'h0);
        check("wrap2_instr", out_instr, 64'h00A0_0093);
        check("wrap2_pc",    pc_addr,   64'h4);

        // Asynchronous reset mid-operation with a full FIFO.
        out_ready = 1'b0;
        step();
        check("ar_full_pc", pc_addr, 64'h8);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", out_valid, 64'h0);
        check("ar_pc",    pc_addr,   64'h0);
        check("ar_opc",   out_pc,    64'h0);
        #1 rst = 1'b0;
        step();
        check("ar1_valid", out_valid, 64'h1);
        check("ar1_opc",   out_pc,    64'h0);
        check("ar1_pc",    pc_addr,   64'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
